// File: rtl/mpeg_es_packer.sv
// ============================================================================
// mpeg_es_packer : packs demuxer payload bytes into 32-bit words and buffers
//                  them in a small FIFO towards the ES decoder.
// Revision 1.0
// ============================================================================
`default_nettype none

module mpeg_es_packer #(
  parameter int DEPTH_LOG2 = 4,
  parameter     unit       = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            mpeg_data,
  input  logic                  data_valid,
  input  logic                  mpeg_packet_body,
  input  logic                  flush,
  output logic [31:0]           es_data,
  output logic [2:0]            es_bytes,
  output logic                  es_valid,
  input  logic                  es_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [31:0]           byte_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic          body_q, body_d;
  logic [23:0]   acc_q, acc_d;
  logic [1:0]    acc_n_q, acc_n_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [34:0]   mem_q [DEPTH];
  logic [34:0]   mem_d [DEPTH];
  logic          overflow_q, overflow_d;
  logic [31:0]   byte_count_q, byte_count_d;

  logic          accept, fall, push, pop, full, wr_en, drop;
  logic [31:0]   merged, push_word;
  logic [2:0]    push_bytes;
  logic [PW-1:0] level;

  assign accept = data_valid & mpeg_packet_body;
  assign fall   = body_q & ~mpeg_packet_body;
  assign body_d = mpeg_packet_body;

  // Current accumulator with the incoming byte dropped into lane acc_n
  always_comb begin
    merged = '0;
    case (acc_n_q)
      2'd0:    merged = {mpeg_data, 24'h0};
      2'd1:    merged = {acc_q[23:16], mpeg_data, 16'h0};
      2'd2:    merged = {acc_q[23:8], mpeg_data, 8'h0};
      default: merged = {acc_q, mpeg_data};
    endcase
  end

  always_comb begin
    acc_d        = acc_q;
    acc_n_d      = acc_n_q;
    push         = 1'b0;
    push_word    = merged;
    push_bytes   = {1'b0, acc_n_q} + 3'd1;
    byte_count_d = byte_count_q + {31'd0, accept};
    if (accept) begin
      if (acc_n_q == 2'd3 || flush) begin
        push    = 1'b1;
        acc_d   = '0;
        acc_n_d = 2'd0;
      end else begin
        acc_d   = merged[31:8];
        acc_n_d = acc_n_q + 2'd1;
      end
    end else if ((flush || fall) && acc_n_q != 2'd0) begin
      // Unused lanes of acc_q are already zero, so the tail is zero-padded
      push       = 1'b1;
      push_word  = {acc_q, 8'h0};
      push_bytes = {1'b0, acc_n_q};
      acc_d      = '0;
      acc_n_d    = 2'd0;
    end
  end

  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = level[PW-1];
  assign es_valid   = (level != '0);
  assign pop        = es_valid & es_ready;
  // When full, the slot being written is the one popped this same cycle
  assign wr_en      = push & (~full | pop);
  assign drop       = push & full & ~pop;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = {push_word, push_bytes};
    wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, wr_en};
    rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      body_q       <= 1'b0;
      acc_q        <= '0;
      acc_n_q      <= 2'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      byte_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      body_q       <= body_d;
      acc_q        <= acc_d;
      acc_n_q      <= acc_n_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      byte_count_q <= byte_count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && drop) $display("%s: ES FIFO full, word dropped", unit);
  end
`endif

  assign es_data    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]][34:3];
  assign es_bytes   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]][2:0];
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign byte_count = byte_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mpeg_es_packer.sv
// ============================================================================
// tb_mpeg_es_packer : directed vectors with hand-computed expected words.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mpeg_es_packer;

  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    mpeg_data;
  logic          data_valid;
  logic          mpeg_packet_body;
  logic          flush;
  logic [31:0]   es_data;
  logic [2:0]    es_bytes;
  logic          es_valid;
  logic          es_ready;
  logic [DL:0]   fifo_level;
  logic          overflow;
  logic [31:0]   byte_count;

  int n_vec = 0;
  int n_err = 0;

  mpeg_es_packer #(.DEPTH_LOG2(DL), .unit("tb_es")) dut (
    .clk              (clk),
    .reset            (reset),
    .mpeg_data        (mpeg_data),
    .data_valid       (data_valid),
    .mpeg_packet_body (mpeg_packet_body),
    .flush            (flush),
    .es_data          (es_data),
    .es_bytes         (es_bytes),
    .es_valid         (es_valid),
    .es_ready         (es_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .byte_count       (byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    mpeg_data  = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] d, input logic [2:0] n);
    chk({tag, "_valid"}, {31'd0, es_valid}, 32'd1);
    chk({tag, "_data"},  es_data, d);
    chk({tag, "_bytes"}, {29'd0, es_bytes}, {29'd0, n});
    es_ready = 1'b1;
    step();
    es_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, es_valid}, 32'd0);
    chk({tag, "_data"},  es_data, 32'd0);
    chk({tag, "_bytes"}, {29'd0, es_bytes}, 32'd0);
    chk({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    chk({tag, "_count"}, byte_count, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mpeg_data = 8'h00; data_valid = 1'b0;
    mpeg_packet_body = 1'b0; flush = 1'b0; es_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk_all_zero("rst");

    // Full-word packing with consumer always ready
    es_ready = 1'b1;
    mpeg_packet_body = 1'b1;
    send(8'h01); send(8'h02); send(8'h03);
    chk("w1_early", {31'd0, es_valid}, 32'd0);
    send(8'h04);
    chk("w1_valid", {31'd0, es_valid}, 32'd1);
    chk("w1_data", es_data, 32'h01020304);
    chk("w1_bytes", {29'd0, es_bytes}, 32'd4);
    send(8'h05);
    chk("w1_popped", {31'd0, es_valid}, 32'd0);
    send(8'h06); send(8'h07); send(8'h08);
    chk("w2_data", es_data, 32'h05060708);
    chk("w2_bytes", {29'd0, es_bytes}, 32'd4);
    mpeg_packet_body = 1'b0;
    step();
    chk("t1_empty", {31'd0, es_valid}, 32'd0);
    chk("t1_count", byte_count, 32'd8);
    es_ready = 1'b0;

    // Header filtering and partial tail at packet end
    for (int i = 0; i < 6; i++) send(8'hE0 + 8'(i));
    chk("hdr_level", {29'd0, fifo_level}, 32'd0);
    mpeg_packet_body = 1'b1;
    for (int i = 0; i < 6; i++) send(8'hAA + 8'(i));
    chk("tail_n", {29'd0, fifo_level}, 32'd1);
    mpeg_packet_body = 1'b0;
    step();
    chk("tail_n1", {29'd0, fifo_level}, 32'd2);
    pop_chk("t2w1", 32'hAAABACAD, 3'd4);
    pop_chk("t2w2", 32'hAEAF0000, 3'd2);
    chk("t2_empty", {31'd0, es_valid}, 32'd0);

    // Flush with a simultaneous byte, then idle flush
    mpeg_packet_body = 1'b1;
    send(8'h11); send(8'h22);
    flush = 1'b1; send(8'h33); flush = 1'b0;
    chk("fl_level", {29'd0, fifo_level}, 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_idle", {29'd0, fifo_level}, 32'd1);
    pop_chk("fl_w", 32'h11223300, 3'd3);
    // Flush coinciding with packet end pushes once
    send(8'h44);
    mpeg_packet_body = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("fe_level", {29'd0, fifo_level}, 32'd1);
    step();
    chk("fe_level2", {29'd0, fifo_level}, 32'd1);
    pop_chk("fe_w", 32'h44000000, 3'd1);
    chk("fe_empty", {31'd0, es_valid}, 32'd0);

    // Backpressure and overflow
    mpeg_packet_body = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send(8'h40 + 8'(i));
      if (i == 15) begin
        chk("ov_full", {29'd0, fifo_level}, 32'd4);
        chk("ov_before", {31'd0, overflow}, 32'd0);
      end
      if (i == 19) chk("ov_set", {31'd0, overflow}, 32'd1);
    end
    chk("ov_level", {29'd0, fifo_level}, 32'd4);
    chk("ov_count", byte_count, 32'd42);
    mpeg_packet_body = 1'b0;
    step();
    pop_chk("ov_w1", 32'h40414243, 3'd4);
    pop_chk("ov_w2", 32'h44454647, 3'd4);
    pop_chk("ov_w3", 32'h48494A4B, 3'd4);
    pop_chk("ov_w4", 32'h4C4D4E4F, 3'd4);
    chk("ov_empty", {31'd0, es_valid}, 32'd0);

    // Full FIFO with push and pop in the same cycle
    reset = 1'b1; step(); reset = 1'b0;
    mpeg_packet_body = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h50 + 8'(i));
    send(8'h60); send(8'h61); send(8'h62);
    chk("pp_full", {29'd0, fifo_level}, 32'd4);
    chk("pp_head", es_data, 32'h50515253);
    es_ready = 1'b1; send(8'h63); es_ready = 1'b0;
    chk("pp_level", {29'd0, fifo_level}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    chk("pp_count", byte_count, 32'd20);
    mpeg_packet_body = 1'b0;
    step();
    pop_chk("pp_w2", 32'h54555657, 3'd4);
    pop_chk("pp_w3", 32'h58595A5B, 3'd4);
    pop_chk("pp_w4", 32'h5C5D5E5F, 3'd4);
    pop_chk("pp_w5", 32'h60616263, 3'd4);
    chk("pp_empty", {31'd0, es_valid}, 32'd0);

    // Reset mid-packet
    mpeg_packet_body = 1'b1;
    for (int i = 0; i < 11; i++) send(8'h70 + 8'(i));
    chk("mr_level", {29'd0, fifo_level}, 32'd2);
    reset = 1'b1; mpeg_packet_body = 1'b0;
    step();
    reset = 1'b0;
    chk_all_zero("mr");
    mpeg_packet_body = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("mr_level2", {29'd0, fifo_level}, 32'd1);
    chk("mr_count", byte_count, 32'd4);
    pop_chk("mr_w", 32'h01020304, 3'd4);
    mpeg_packet_body = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
